// File: rtl/multi_domain_power_fsm.sv
// Per-domain power-state controller: one ACTIVE/IDLE/SLEEP/DEEP/WAKE/THROTTLE FSM per domain.
// Optional DEEP residency counters are enabled with the POWER_FSM_RESIDENCY_EN macro.
module multi_domain_power_fsm #(
    parameter int unsigned NUM_DOMAINS   = 4,
    parameter int unsigned TIMER_W       = 16,
    parameter int unsigned WAKE_LAT      = 8,
    parameter int unsigned THROTTLE_HOLD = 1000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      pm_enable_i,
    input  logic [TIMER_W-1:0]        idle_timeout_i,
    input  logic [TIMER_W-1:0]        sleep_timeout_i,
    input  logic [NUM_DOMAINS-1:0]    dom_idle_i,
    input  logic [NUM_DOMAINS-1:0]    dom_wake_i,
    input  logic                      thermal_alert_i,
    input  logic [NUM_DOMAINS-1:0]    pwr_ack_i,
    output logic [NUM_DOMAINS-1:0]    pwr_req_o,
    output logic [NUM_DOMAINS-1:0]    clk_gate_o,
    output logic [3*NUM_DOMAINS-1:0]  dom_state_o,
    output logic [NUM_DOMAINS-1:0]    dom_ready_o,
    output logic                      any_throttle_o,
    input  logic                      res_clr_i,
    output logic [32*NUM_DOMAINS-1:0] res_cnt_o
);

    localparam int unsigned          StateW    = 3;
    localparam int unsigned          ResW      = 32;
    localparam logic [TIMER_W-1:0]   WakeLast  = TIMER_W'(WAKE_LAT - 1);
    localparam logic [TIMER_W-1:0]   HoldLast  = TIMER_W'(THROTTLE_HOLD - 1);

    typedef enum logic [StateW-1:0] {
        ST_ACTIVE   = 3'd0,
        ST_IDLE     = 3'd1,
        ST_SLEEP    = 3'd2,
        ST_DEEP     = 3'd3,
        ST_WAKE     = 3'd4,
        ST_THROTTLE = 3'd5
    } state_e;

    state_e               state_q [NUM_DOMAINS];
    state_e               state_d [NUM_DOMAINS];
    logic [TIMER_W-1:0]   timer_q [NUM_DOMAINS];
    logic [TIMER_W-1:0]   timer_d [NUM_DOMAINS];

    logic [NUM_DOMAINS-1:0] pwr_req_q,  pwr_req_d;
    logic [NUM_DOMAINS-1:0] clk_gate_q, clk_gate_d;
    logic [NUM_DOMAINS-1:0] ready_q,    ready_d;
    logic [NUM_DOMAINS-1:0] thr_d;
    logic                   any_thr_q;

    function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
        return (&v) ? v : v + TIMER_W'(1);
    endfunction

    // Next state and timer per domain; thermal outranks wake/disable, which outranks timeouts.
    always_comb begin
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = sat_inc(timer_q[i]);
            case (state_q[i])
                ST_ACTIVE: begin
                    if (thermal_alert_i)
                        state_d[i] = ST_THROTTLE;
                    else if (pm_enable_i && dom_idle_i[i] && !dom_wake_i[i])
                        state_d[i] = ST_IDLE;
                end
                ST_IDLE, ST_SLEEP: begin
                    if (thermal_alert_i)
                        state_d[i] = ST_THROTTLE;
                    else if (dom_wake_i[i] || !dom_idle_i[i] || !pm_enable_i)
                        state_d[i] = ST_ACTIVE;
                    else if (state_q[i] == ST_IDLE && timer_q[i] >= idle_timeout_i)
                        state_d[i] = ST_SLEEP;
                    else if (state_q[i] == ST_SLEEP && timer_q[i] >= sleep_timeout_i)
                        state_d[i] = ST_DEEP;
                end
                ST_DEEP: begin
                    if (dom_wake_i[i] || !pm_enable_i)
                        state_d[i] = ST_WAKE;
                end
                ST_WAKE: begin
                    // Settle count only starts once the switch reports power restored.
                    if (pwr_ack_i[i])
                        timer_d[i] = '0;
                    else if (timer_q[i] == WakeLast)
                        state_d[i] = ST_ACTIVE;
                end
                ST_THROTTLE: begin
                    if (thermal_alert_i)
                        timer_d[i] = '0;
                    else if (timer_q[i] >= HoldLast)
                        state_d[i] = ST_ACTIVE;
                end
                default: state_d[i] = ST_ACTIVE;
            endcase
            if (state_d[i] != state_q[i])
                timer_d[i] = '0;
        end
    end

    // Output decodes of the next state, so the registered outputs line up with state_q.
    always_comb begin
        pwr_req_d  = '0;
        clk_gate_d = '0;
        ready_d    = '0;
        thr_d      = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            pwr_req_d[i]  = (state_d[i] == ST_DEEP);
            clk_gate_d[i] = (state_d[i] == ST_SLEEP) || (state_d[i] == ST_DEEP) ||
                            (state_d[i] == ST_WAKE);
            ready_d[i]    = (state_d[i] == ST_ACTIVE) || (state_d[i] == ST_IDLE);
            thr_d[i]      = (state_d[i] == ST_THROTTLE);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                state_q[i] <= ST_ACTIVE;
                timer_q[i] <= '0;
            end
            pwr_req_q  <= '0;
            clk_gate_q <= '0;
            ready_q    <= '1;
            any_thr_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
            pwr_req_q  <= pwr_req_d;
            clk_gate_q <= clk_gate_d;
            ready_q    <= ready_d;
            any_thr_q  <= |thr_d;
        end
    end

    always_comb begin
        dom_state_o = '0;
        for (int i = 0; i < NUM_DOMAINS; i++)
            dom_state_o[StateW*i +: StateW] = state_q[i];
    end

    assign pwr_req_o      = pwr_req_q;
    assign clk_gate_o     = clk_gate_q;
    assign dom_ready_o    = ready_q;
    assign any_throttle_o = any_thr_q;

`ifdef POWER_FSM_RESIDENCY_EN
    logic [ResW-1:0] res_q [NUM_DOMAINS];

    // Saturating DEEP residency; a clear outranks the increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_DOMAINS; i++)
                res_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                if (res_clr_i)
                    res_q[i] <= '0;
                else if (state_q[i] == ST_DEEP && !(&res_q[i]))
                    res_q[i] <= res_q[i] + ResW'(1);
            end
        end
    end

    always_comb begin
        res_cnt_o = '0;
        for (int i = 0; i < NUM_DOMAINS; i++)
            res_cnt_o[ResW*i +: ResW] = res_q[i];
    end
`else
    logic unused_res_clr;
    assign unused_res_clr = res_clr_i;
    assign res_cnt_o      = '0;
`endif

endmodule
